toggle_hs_rx: RTL

Receiving end of the team's toggle-based request/acknowledge handshake. Detects a level change on an asynchronous request-toggle line, captures the accompanying data word, presents it on a valid/ready interface, and returns completion by toggling an acknowledge line. One instance pairs with one toggle-handshake transmitter. Together they provide a single-word-in-flight crossing from a foreign clock domain into the `clk` domain.

---
 rtl/toggle_hs_pkg.sv | 21 ++
 rtl/toggle_hs_rx_sync_bit.sv | 32 +++
 rtl/toggle_hs_rx.sv | 92 +++++++++
 3 files changed

// File: rtl/toggle_hs_pkg.sv
// ============================================================================
// Module      : toggle_hs_pkg
// Description : Shared state encoding and parameter defaults for the
//               toggle-handshake receiver and transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package toggle_hs_pkg;

    localparam int TGL_DATA_W_DEF      = 8;
    localparam int TGL_SYNC_STAGES_DEF = 2;

    typedef enum logic [0:0] {
        TGL_IDLE = 1'b0,
        TGL_HOLD = 1'b1
    } tgl_state_t;

endpackage : toggle_hs_pkg

`default_nettype wire

// File: rtl/toggle_hs_rx_sync_bit.sv
// ============================================================================
// Module      : sync_bit
// Description : N-stage single-bit synchronizer, cleared by reset.
//               Shared by both ends of the toggle handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : sync_bit

`default_nettype wire

// File: rtl/toggle_hs_rx.sv
// ============================================================================
// Module      : toggle_hs_rx
// Description : Toggle-handshake receiver; captures one word per req_tgl
//               change and returns completion on ack_tgl.
//               Optional sticky protocol check: TOGGLE_HS_RX_ERRCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = TGL_DATA_W_DEF,
    parameter int SYNC_STAGES = TGL_SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef TOGGLE_HS_RX_ERRCHK_EN
    ,
    output logic              proto_err
`endif
);

    tgl_state_t r_state;
    logic       r_prev;
    logic       w_s_q;
    logic       w_tgl_det;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_tgl),
        .q     (w_s_q)
    );

    // r_prev only advances on capture, so a toggle seen in HOLD stays pending.
    assign w_tgl_det = w_s_q ^ r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TGL_IDLE;
            r_prev    <= 1'b0;
            ack_tgl   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (r_state)
                TGL_IDLE: begin
                    if (w_tgl_det) begin
                        out_data  <= req_data;
                        r_prev    <= w_s_q;
                        out_valid <= 1'b1;
                        r_state   <= TGL_HOLD;
                    end
                end
                TGL_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ack_tgl   <= ~ack_tgl;
                        r_state   <= TGL_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= TGL_IDLE;
                end
            endcase
        end
    end

`ifdef TOGGLE_HS_RX_ERRCHK_EN
    // A second toggle before our ack means the transmitter broke protocol.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if ((r_state == TGL_HOLD) && w_tgl_det) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule : toggle_hs_rx

`default_nettype wire
